matmul_result_buffer: RTL and testbench
=======================================

// Module: matmul_result_buffer
// PURPOSE
//  Store-and-forward frame buffer that sits directly downstream of the 4x4 matrix multiplier.
//  Accepts the 16-word C-matrix result stream on an AXI-Stream slave port and holds up to
//  NUM_FRAMES complete frames. Releases only whole frames on an AXI-Stream master port
//  toward the DMA/host, so that back-pressure never stalls the multiplier mid-frame.
//  Checks the incoming frame length against ss_tlast and counts the frames it emits.
// PARAMETERS
//  pDATA_WIDTH  32  width of each stream data word
//  FRAME_LEN    16  words per frame (one 4x4 result matrix); must be a power of 2, >= 2
//  NUM_FRAMES   2   frame capacity; DEPTH = FRAME_LEN*NUM_FRAMES; must be a power of 2
// PORTS
//  axis_clk    in   1            clock; all logic is on the rising edge
//  axis_rst_n  in   1            synchronous, active-high reset (1 = reset)
//  ss_tvalid   in   1            input word valid (from the multiplier's sm_tvalid)
//  ss_tdata    in   pDATA_WIDTH  input word
//  ss_tlast    in   1            input end-of-frame marker; checked only, never used for framing
//  ss_tready   out  1            buffer can accept a word
//  sm_tready   in   1            downstream ready
//  sm_tvalid   out  1            output word valid
//  sm_tdata    out  pDATA_WIDTH  output word
//  sm_tlast    out  1            high on word FRAME_LEN-1 of each output frame
//  frame_cnt   out  16           frames fully emitted; wraps modulo 2^16
//  len_err     out  1            sticky frame-length error flag
//  err_clr     in   1            single-cycle clear for len_err
// BEHAVIOUR
//  - Reset (axis_rst_n=1 at a clock edge) sets the following to 0: sm_tvalid, sm_tlast,
//    sm_tdata, frame_cnt, len_err, pointers, word count, frames_ready, in_idx and out_idx.
//    It sets the state to IDLE. Any partial frame is discarded.
//    ss_tready is 1 in the first cycle after reset. Buffer RAM contents need not be cleared.
//  - Storage is a circular buffer of DEPTH words with wr_ptr, rd_ptr and count (0..DEPTH).
//    Both pointers wrap from DEPTH-1 to 0.
//  - Input: ss_tready = (count != DEPTH), decoded combinationally from registered count.
//    A write occurs when ss_tvalid && ss_tready. On a write: mem[wr_ptr] <= ss_tdata,
//    wr_ptr++, and in_idx increments, wrapping at FRAME_LEN-1.
//  - Frame completion: a write with in_idx==FRAME_LEN-1 increments frames_ready.
//  - Length check (on each write): set len_err if ss_tlast && in_idx!=FRAME_LEN-1, or if
//    !ss_tlast && in_idx==FRAME_LEN-1. The frame is still closed by count alone.
//    err_clr clears len_err; if a set and a clear fall in the same cycle, set wins.
//  - Output FSM:
//    IDLE -> SEND when frames_ready != 0.
//    SEND: sm_tvalid=1, sm_tdata=mem[rd_ptr], sm_tlast=(out_idx==FRAME_LEN-1).
//    A handshake (sm_tvalid && sm_tready) does rd_ptr++ and out_idx++ (wrapping).
//    The handshake on the last word also does frames_ready-- and frame_cnt++. SEND then
//    stays in SEND (back-to-back frames) if another frame is complete, else goes to IDLE.
//  - AXIS hold rule: once sm_tvalid is high, sm_tvalid, sm_tdata and sm_tlast stay stable
//    until the handshake. Stored words are never overwritten before they are read.
//  - Latency: the last input word handshakes at edge E; frames_ready updates at E; state is
//    SEND from E+1. sm_tvalid is therefore high in the second cycle after the handshake cycle.
//  - Simultaneous events:
//    write and read in one cycle: count unchanged.
//    frame completes on input and on output in one cycle: frames_ready unchanged.
//  - Full: while count==DEPTH, ss_tready=0 even if a read happens in the same cycle
//    (no bypass). ss_tready returns to 1 in the cycle after the read.
//  - Empty: count==0 implies IDLE and sm_tvalid=0. A partial frame is never emitted.
//  - Reset mid-operation (during input or output): all state is cleared per reset rule.
//    sm_tvalid is 0 in the cycle after the reset edge.
// TESTING
//  1. Assert reset for 2 cycles, then release -> sm_tvalid=0, frame_cnt=0, len_err=0,
//     ss_tready=1.
//  2. Drive words 1..16 with tlast on 16, sm_tready=1 -> sm_tvalid rises 2 cycles after
//     word 16. Outputs are 1..16 with sm_tlast only on 16; frame_cnt=1, len_err=0.
//  3. sm_tready=0, stream 33 words -> ss_tready=0 after word 32 and word 33 stalls.
//     Raise sm_tready -> 32 words out in order with tlast on words 16 and 32;
//     word 33 is then accepted.
//  4. Frame with tlast on word 10 and none on 16 -> len_err=1, and 16 words are still
//     emitted. Pulse err_clr -> len_err=0 next cycle.
//  5. Random sm_tready (50%) over 8 frames -> sm_tdata/sm_tlast stable while
//     valid&&!ready, no loss or reorder, frame_cnt=8.
//  6. Reset after 5 words of an output frame -> sm_tvalid=0 next cycle, count=0.
//     A following fresh frame is emitted correctly.

Source files
------------

// File: rtl/matmul_result_buffer.sv
// Store-and-forward buffer for 4x4 matmul result frames: accepts words on an AXIS slave,
// releases only complete frames on an AXIS master, and flags frame-length mismatches.
module matmul_result_buffer #(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN   = 16,
    parameter int unsigned NUM_FRAMES  = 2
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic [15:0]            frame_cnt,
    output logic                   len_err,
    input  logic                   err_clr
);

    localparam int unsigned DEPTH = FRAME_LEN * NUM_FRAMES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(FRAME_LEN);
    localparam int unsigned FW    = $clog2(NUM_FRAMES + 1);

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [pDATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [IW-1:0]          r_in_idx;
    logic [IW-1:0]          r_out_idx;
    logic [FW-1:0]          r_frames_ready;
    state_t                 r_state;
    logic                   r_tvalid;
    logic [pDATA_WIDTH-1:0] r_tdata;
    logic                   r_tlast;
    logic [15:0]            r_frame_cnt;
    logic                   r_len_err;

    logic                   w_ss_ready;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_in_done;
    logic                   w_out_done;
    logic                   w_len_bad;
    logic [FW-1:0]          w_frames_nx;
    logic [AW-1:0]          w_rd_ptr_nx;
    logic [IW-1:0]          w_out_idx_nx;

    assign ss_tready = w_ss_ready;
    assign sm_tvalid = r_tvalid;
    assign sm_tdata  = r_tdata;
    assign sm_tlast  = r_tlast;
    assign frame_cnt = r_frame_cnt;
    assign len_err   = r_len_err;

    always_comb begin
        w_ss_ready   = (r_count != FULL);
        w_wr         = ss_tvalid && w_ss_ready;
        w_rd         = r_tvalid && sm_tready;
        w_in_done    = w_wr && (r_in_idx == LAST_IDX);
        w_out_done   = w_rd && (r_out_idx == LAST_IDX);
        w_len_bad    = w_wr && (ss_tlast != (r_in_idx == LAST_IDX));
        w_rd_ptr_nx  = r_rd_ptr + 1'b1;
        w_out_idx_nx = r_out_idx + 1'b1;
        w_frames_nx  = r_frames_ready;
        if (w_in_done && !w_out_done) begin
            w_frames_nx = r_frames_ready + 1'b1;
        end else if (w_out_done && !w_in_done) begin
            w_frames_nx = r_frames_ready - 1'b1;
        end
    end

    // Storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge axis_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= ss_tdata;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_in_idx       <= '0;
            r_out_idx      <= '0;
            r_frames_ready <= '0;
            r_state        <= IDLE;
            r_tvalid       <= 1'b0;
            r_tdata        <= '0;
            r_tlast        <= 1'b0;
            r_frame_cnt    <= '0;
            r_len_err      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_in_idx <= r_in_idx + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr  <= w_rd_ptr_nx;
                r_out_idx <= w_out_idx_nx;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_frames_ready <= w_frames_nx;

            if (w_len_bad) begin
                r_len_err <= 1'b1;
            end else if (err_clr) begin
                r_len_err <= 1'b0;
            end

            if (w_out_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            // Output word is prefetched from rd_ptr+1 at each handshake so that the
            // registered sm_tdata is already valid when the next word is presented.
            case (r_state)
                IDLE: begin
                    if (r_frames_ready != '0) begin
                        r_state  <= SEND;
                        r_tvalid <= 1'b1;
                        r_tdata  <= r_mem[r_rd_ptr];
                        r_tlast  <= (r_out_idx == LAST_IDX);
                    end
                end
                SEND: begin
                    if (w_rd) begin
                        if (w_out_done && (w_frames_nx == '0)) begin
                            r_state  <= IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                        end else begin
                            r_tdata <= r_mem[w_rd_ptr_nx];
                            r_tlast <= (w_out_idx_nx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_buffer.sv
// Scoreboard bench for matmul_result_buffer: accepted words are queued as expectations,
// a negedge monitor pops and compares every output handshake and checks AXIS hold.
module tb_matmul_result_buffer;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;
    logic        sm_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic [15:0] frame_cnt;
    logic        len_err;
    logic        err_clr;

    logic        rand_on;
    logic        ready_fixed;
    exp_t        exp_q[$];
    int          n_checks;
    int          n_err;
    int          n_pops;
    int          tb_in_idx;

    logic        p_stall;
    logic [31:0] p_data;
    logic        p_last;

    matmul_result_buffer #(
        .pDATA_WIDTH(32),
        .FRAME_LEN  (16),
        .NUM_FRAMES (2)
    ) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .sm_tready (sm_tready),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast),
        .frame_cnt (frame_cnt),
        .len_err   (len_err),
        .err_clr   (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #2;
        sm_tready = rand_on ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_valid", {31'd0, sm_tvalid}, 32'd1);
                chk("hold_data", sm_tdata, p_data);
                chk("hold_last", {31'd0, sm_tlast}, {31'd0, p_last});
            end
            if (sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", sm_tdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", sm_tdata, e.d);
                    chk("out_last", {31'd0, sm_tlast}, {31'd0, e.l});
                    n_pops++;
                end
            end
            p_stall = sm_tvalid && !sm_tready;
            p_data  = sm_tdata;
            p_last  = sm_tlast;
        end
    end

    // Called and returns at posedge+1.
    task automatic send_word(input logic [31:0] d, input logic l);
        int unsigned t;
        bit ok;
        ok = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ss_tready) begin
                exp_q.push_back('{d: d, l: (tb_in_idx == 15)});
                tb_in_idx = (tb_in_idx + 1) % 16;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", d, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int tpos);
        for (int i = 0; i < 16; i++) begin
            send_word(base + 32'(i), (i == tpos));
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !sm_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("len_err_cleared", {31'd0, len_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_checks = 0; n_err = 0; n_pops = 0; tb_in_idx = 0;
        rst = 1'b1; ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
        err_clr = 1'b0; rand_on = 1'b0; ready_fixed = 1'b1;
        p_stall = 1'b0; p_data = '0; p_last = 1'b0;

        // Reset for 2 cycles
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_tvalid", {31'd0, sm_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, sm_tlast}, 32'd0);
        chk("rst_tdata", sm_tdata, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        chk("rst_ss_tready", {31'd0, ss_tready}, 32'd1);

        // Single frame 1..16, latency of two cycles to sm_tvalid
        send_frame(32'd1, 15);
        chk("lat_cycle1_tvalid", {31'd0, sm_tvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_tvalid", {31'd0, sm_tvalid}, 32'd1);
        drain();
        chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t2_len_err", {31'd0, len_err}, 32'd0);

        // Full buffer: 32 words fit, word 33 stalls until a read
        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 32; k++) send_word(32'h300 + 32'(k), (k % 16) == 0);
        ss_tvalid = 1'b1;
        ss_tdata  = 32'h321;
        @(negedge clk);
        chk("full_ss_tready", {31'd0, ss_tready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_still_stalled", {31'd0, ss_tready}, 32'd0);
        chk("full_tvalid", {31'd0, sm_tvalid}, 32'd1);
        ready_fixed = 1'b1;
        for (int k = 33; k <= 48; k++) send_word(32'h300 + 32'(k), (k % 16) == 0);
        drain();
        chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        chk("t3_len_err", {31'd0, len_err}, 32'd0);

        // Length error: tlast on word 10, none on 16
        send_frame(32'd100, 9);
        chk("t4_len_err_set", {31'd0, len_err}, 32'd1);
        drain();
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("t4_len_err_sticky", {31'd0, len_err}, 32'd1);
        pulse_clr();
        // Set and clear in the same cycle: set wins
        err_clr = 1'b1;
        send_word(32'd200, 1'b1);
        err_clr = 1'b0;
        chk("t4_set_wins", {31'd0, len_err}, 32'd1);
        for (int i = 1; i < 16; i++) send_word(32'd200 + 32'(i), (i == 15));
        drain();
        chk("t4b_frame_cnt", {16'd0, frame_cnt}, 32'd6);
        pulse_clr();

        // Random back-pressure over 8 frames
        rand_on = 1'b1;
        for (int f = 0; f < 8; f++) send_frame(32'd1000 + 32'(f * 16), 15);
        drain();
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd14);
        chk("t5_len_err", {31'd0, len_err}, 32'd0);

        // Reset after 5 words of an output frame
        p0 = n_pops;
        send_frame(32'd500, 15);
        for (int t = 0; t < 100; t++) begin
            if (n_pops - p0 >= 5) break;
            @(posedge clk);
            #1;
        end
        chk("t6_pops_before_rst", 32'(n_pops - p0), 32'd5);
        rst = 1'b1;
        exp_q.delete();
        tb_in_idx = 0;
        @(posedge clk);
        #1;
        chk("t6_tvalid_after_rst", {31'd0, sm_tvalid}, 32'd0);
        chk("t6_ss_tready", {31'd0, ss_tready}, 32'd1);
        chk("t6_frame_cnt_rst", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_idle_tvalid", {31'd0, sm_tvalid}, 32'd0);
        send_frame(32'd600, 15);
        drain();
        chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t6_len_err", {31'd0, len_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
